multi_tick_timer: RTL

- Parametrised tick generator for game timing: fruit spawn intervals, animation frame steps, round countdown.
- A shared prescaler divides clk into a base tick every CLK_DIV cycles.
- NUM_CH independent channels count base ticks against a runtime-loaded period. Each emits a one-cycle tick per period, in periodic or one-shot mode.
- Sits between the system clock and the game FSM / render logic. It replaces the fixed single-rate tick generators.

---
 rtl/multi_tick_timer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/multi_tick_timer.sv
// multi_tick_timer: shared prescaler producing a base tick every CLK_DIV
// enabled cycles, feeding NUM_CH independent period counters that each emit
// a one-cycle tick per completed period (periodic or one-shot).
//
// Optional feature macro: MULTI_TICK_TIMER_CNT_OUT_EN
//   defined   -> adds output cnt_out, the live counter of every channel
//                (channel i at bits [i*PERIOD_W +: PERIOD_W]), unregistered.
//   undefined -> cnt_out is absent; behaviour is otherwise identical.

// ---------------------------------------------------------------------------
// One timer channel: IDLE/RUN state machine with period register and counter.
// ---------------------------------------------------------------------------
module multi_tick_timer_ch #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                base_ev,
    input  logic                ch_en,
    input  logic                oneshot,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period_in,
    output logic                tick,
    output logic                busy
`ifdef MULTI_TICK_TIMER_CNT_OUT_EN
    ,
    output logic [PERIOD_W-1:0] cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

    ch_state_e           state_q, state_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                tick_q, tick_d;

    // Next-state: load has priority over counting; IDLE ignores base ticks.
    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (load) begin
            // A zero period parks the channel in IDLE so cnt never underflows.
            per_d   = period_in;
            cnt_d   = period_in;
            state_d = (period_in != '0) ? RUN : IDLE;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (base_ev && ch_en) begin
                        if (cnt_q == CNT_ONE) begin
                            tick_d = 1'b1;
                            if (oneshot) begin
                                cnt_d   = '0;
                                state_d = IDLE;
                            end else begin
                                cnt_d = per_q;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Channel registers; tick is registered so it lines up with base_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            per_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;
    assign busy = (state_q == RUN);
`ifdef MULTI_TICK_TIMER_CNT_OUT_EN
    assign cnt  = cnt_q;
`endif

endmodule

// ---------------------------------------------------------------------------
// Top: prescaler plus an array of channels.
// ---------------------------------------------------------------------------
module multi_tick_timer #(
    parameter int CLK_DIV  = 500000,
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic [NUM_CH-1:0]   ch_oneshot,
    input  logic [NUM_CH-1:0]   load,
    input  logic [PERIOD_W-1:0] period_in,
    output logic                base_tick,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   busy
`ifdef MULTI_TICK_TIMER_CNT_OUT_EN
    ,
    output logic [NUM_CH*PERIOD_W-1:0] cnt_out
`endif
);

    // CLK_DIV=1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int               PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             base_tick_q, base_tick_d;
    logic             base_ev;

    // Prescaler: wraps on the base event, holds while globally disabled.
    always_comb begin
        base_ev     = en && (pre_cnt_q == PRE_MAX);
        pre_cnt_d   = pre_cnt_q;
        base_tick_d = base_ev;
        if (base_ev) begin
            pre_cnt_d = '0;
        end else if (en) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    // Prescaler registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q   <= '0;
            base_tick_q <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            base_tick_q <= base_tick_d;
        end
    end

    assign base_tick = base_tick_q;

    // Channels share base_ev and period_in; everything else is per channel.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        multi_tick_timer_ch #(
            .PERIOD_W (PERIOD_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .base_ev   (base_ev),
            .ch_en     (ch_en[i]),
            .oneshot   (ch_oneshot[i]),
            .load      (load[i]),
            .period_in (period_in),
            .tick      (tick[i]),
            .busy      (busy[i])
`ifdef MULTI_TICK_TIMER_CNT_OUT_EN
            ,
            .cnt       (cnt_out[i*PERIOD_W +: PERIOD_W])
`endif
        );
    end

endmodule
